// File: rtl/squeeze_f.sv
// Iterated permutation core: loads (c, x, r) one cycle after reset release,
// runs `rounds` 32-bit word-mixing rounds, then holds the result with done=1.
module squeeze_f #(
   parameter int unsigned XWORDS32    = 2,
   parameter int unsigned DS_WIDTH    = 4,
   parameter int unsigned ROUND_COUNT = 4,
   parameter int unsigned RWIDTH      = 32,
   parameter int unsigned CWIDTH      = 320,
   parameter int unsigned IWIDTH      = 128
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [IWIDTH-1:0]        i,
   input  logic [ROUND_COUNT-1:0]   rounds,
   input  logic [DS_WIDTH-1:0]      ds,
   input  logic [CWIDTH-1:0]        c,
   input  logic [RWIDTH-1:0]        r,
   input  logic [XWORDS32*32-1:0]   x,
   output logic [CWIDTH-1:0]        cout,
   output logic [RWIDTH-1:0]        rout,
   output logic [XWORDS32*32-1:0]   xout,
   output logic                     done
);

   localparam int unsigned XWIDTH = XWORDS32 * 32;
   localparam int unsigned SW     = CWIDTH + XWIDTH + RWIDTH;

   typedef enum logic [1:0] {F_LOAD, F_RUN, F_FIN} f_state_t;

   f_state_t               phase, phase_d;
   logic [SW-1:0]          st, st_d, rnd_st;
   logic [ROUND_COUNT-1:0] cnt, cnt_d;
   logic                   done_d;
   logic [31:0]            t;

   // One round: new word from words 0, 1 and last, then shift the word list down.
   always_comb begin
      t = (st[31:0] ^ st[SW-1 -: 32]) + {st[58:32], st[63:59]} + 32'({ds, cnt});
      rnd_st = {t, st[SW-1:32]};
      rnd_st[31:0] = rnd_st[31:0] ^ t;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase <= F_LOAD;
         st    <= '0;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         phase <= phase_d;
         st    <= st_d;
         cnt   <= cnt_d;
         done  <= done_d;
      end
   end

   always_comb begin
      phase_d = phase;
      st_d    = st;
      cnt_d   = cnt;
      done_d  = done;
      unique case (phase)
         F_LOAD: begin
            st_d    = {c ^ CWIDTH'(i), x, r};
            cnt_d   = '0;
            phase_d = F_RUN;
         end
         F_RUN: begin
            if (cnt == rounds) begin
               done_d  = 1'b1;
               phase_d = F_FIN;
            end else begin
               st_d  = rnd_st;
               cnt_d = cnt + ROUND_COUNT'(1);
            end
         end
         F_FIN: ;
         default: phase_d = F_LOAD;
      endcase
   end

   assign cout = st[SW-1 -: CWIDTH];
   assign xout = st[RWIDTH +: XWIDTH];
   assign rout = st[RWIDTH-1:0];

endmodule

// File: rtl/squeeze.sv
// Sponge squeeze phase: streams nblocks rate blocks over valid/ready,
// running one F permutation between consecutive blocks.
module squeeze #(
   parameter int unsigned CWIDTH = 320,
   parameter int unsigned RWIDTH = 32,
   parameter int unsigned XWIDTH = 64,
   parameter int unsigned IWIDTH = 128,
   parameter int unsigned NWIDTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CWIDTH-1:0] c,
   input  logic [RWIDTH-1:0] r,
   input  logic [XWIDTH-1:0] x,
   input  logic [NWIDTH-1:0] nblocks,
   input  logic [1:0]        domain,
   input  logic [3:0]        rounds,
   output logic [RWIDTH-1:0] out_block,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [CWIDTH-1:0] cout,
   output logic [RWIDTH-1:0] rout,
   output logic [XWIDTH-1:0] xout,
   output logic              busy,
   output logic              done
);

   localparam int unsigned DS_WIDTH = 4;
   localparam int unsigned RC_WIDTH = 4;

   typedef enum logic [2:0] {
      S_IDLE, S_EMIT, S_PERM_START, S_PERM_WAIT, S_DONE
   } state_t;

   state_t                state, state_d;
   logic [CWIDTH-1:0]     c_reg, c_d;
   logic [RWIDTH-1:0]     r_reg, r_d;
   logic [XWIDTH-1:0]     x_reg, x_d;
   logic [NWIDTH-1:0]     n_reg, n_d, cnt, cnt_d;
   logic [1:0]            dom_reg, dom_d;
   logic [RC_WIDTH-1:0]   rnd_reg, rnd_d;

   logic [RWIDTH-1:0]     out_block_d;
   logic                  out_valid_d, out_last_d, busy_d, done_d;
   logic [CWIDTH-1:0]     cout_d;
   logic [RWIDTH-1:0]     rout_d;
   logic [XWIDTH-1:0]     xout_d;

   logic                  f_reset, f_reset_d, f_rst, f_done;
   logic [IWIDTH-1:0]     f_i;
   logic [DS_WIDTH-1:0]   f_ds;
   logic [CWIDTH-1:0]     f_cout;
   logic [RWIDTH-1:0]     f_rout;
   logic [XWIDTH-1:0]     f_xout;

   assign f_i   = '0;
   assign f_ds  = {dom_reg, 1'b1, 1'b0};
   assign f_rst = reset | f_reset;

   squeeze_f #(
      .XWORDS32   (XWIDTH / 32),
      .DS_WIDTH   (DS_WIDTH),
      .ROUND_COUNT(RC_WIDTH),
      .RWIDTH     (RWIDTH),
      .CWIDTH     (CWIDTH),
      .IWIDTH     (IWIDTH)
   ) u_f (
      .clk   (clk),
      .reset (f_rst),
      .i     (f_i),
      .rounds(rnd_reg),
      .ds    (f_ds),
      .c     (c_reg),
      .r     (r_reg),
      .x     (x_reg),
      .cout  (f_cout),
      .rout  (f_rout),
      .xout  (f_xout),
      .done  (f_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         c_reg     <= '0;
         r_reg     <= '0;
         x_reg     <= '0;
         n_reg     <= '0;
         cnt       <= '0;
         dom_reg   <= '0;
         rnd_reg   <= '0;
         out_block <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         cout      <= '0;
         rout      <= '0;
         xout      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         f_reset   <= 1'b1;
      end else begin
         state     <= state_d;
         c_reg     <= c_d;
         r_reg     <= r_d;
         x_reg     <= x_d;
         n_reg     <= n_d;
         cnt       <= cnt_d;
         dom_reg   <= dom_d;
         rnd_reg   <= rnd_d;
         out_block <= out_block_d;
         out_valid <= out_valid_d;
         out_last  <= out_last_d;
         cout      <= cout_d;
         rout      <= rout_d;
         xout      <= xout_d;
         busy      <= busy_d;
         done      <= done_d;
         f_reset   <= f_reset_d;
      end
   end

   always_comb begin
      state_d = state;
      c_d     = c_reg;
      r_d     = r_reg;
      x_d     = x_reg;
      n_d     = n_reg;
      cnt_d   = cnt;
      dom_d   = dom_reg;
      rnd_d   = rnd_reg;
      cout_d  = cout;
      rout_d  = rout;
      xout_d  = xout;

      unique case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               c_d     = c;
               r_d     = r;
               x_d     = x;
               n_d     = nblocks;
               dom_d   = domain;
               rnd_d   = rounds;
               cnt_d   = '0;
               state_d = (nblocks == '0) ? S_DONE : S_EMIT;
            end
         end
         S_EMIT: begin
            if (out_valid && out_ready) begin
               cnt_d   = cnt + NWIDTH'(1);
               state_d = (cnt == n_reg - NWIDTH'(1)) ? S_DONE : S_PERM_START;
            end
         end
         S_PERM_START: state_d = S_PERM_WAIT;
         S_PERM_WAIT: begin
            if (f_done) begin
               c_d     = f_cout;
               r_d     = f_rout;
               x_d     = f_xout;
               state_d = S_EMIT;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered images of the next state and next working regs.
      out_valid_d = (state_d == S_EMIT);
      out_block_d = (state_d == S_EMIT) ? r_d : '0;
      out_last_d  = (state_d == S_EMIT) && (cnt_d == n_d - NWIDTH'(1));
      busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d      = (state_d == S_DONE);
      f_reset_d   = (state_d != S_PERM_WAIT);
      if (state_d == S_DONE) begin
         cout_d = c_d;
         rout_d = r_d;
         xout_d = x_d;
      end
   end

endmodule

// File: tb/tb_squeeze.sv
// Self-checking bench for squeeze: table of requests checked against a
// word-level sponge model, plus hand-written abort and busy-start sequences.
module tb_squeeze;

   localparam int unsigned CW = 320;
   localparam int unsigned RW = 32;
   localparam int unsigned XW = 64;
   localparam int unsigned NW = 8;
   localparam int unsigned NWORDS = 13;
   localparam int unsigned NVEC = 10;

   logic          clk = 1'b0;
   logic          reset, start, out_ready;
   logic [CW-1:0] c, cout;
   logic [RW-1:0] r, rout, out_block;
   logic [XW-1:0] x, xout;
   logic [NW-1:0] nblocks;
   logic [1:0]    domain;
   logic [3:0]    rounds;
   logic          out_valid, out_last, busy, done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   squeeze dut (
      .clk(clk), .reset(reset), .start(start), .c(c), .r(r), .x(x),
      .nblocks(nblocks), .domain(domain), .rounds(rounds),
      .out_block(out_block), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .cout(cout), .rout(rout), .xout(xout),
      .busy(busy), .done(done)
   );

   task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model: state as a list of 32-bit words ----------------
   typedef logic [31:0] words_t [NWORDS];

   function automatic words_t to_words(input logic [CW-1:0] cc, input logic [31:0] rr,
                                       input logic [XW-1:0] xx);
      words_t w;
      w[0] = rr;
      w[1] = xx[31:0];
      w[2] = xx[63:32];
      for (int k = 0; k < 10; k++) w[3+k] = cc[32*k +: 32];
      return w;
   endfunction

   function automatic logic [CW-1:0] words_c(input words_t w);
      logic [CW-1:0] cc;
      for (int k = 0; k < 10; k++) cc[32*k +: 32] = w[3+k];
      return cc;
   endfunction

   function automatic words_t perm(input words_t w_in, input logic [3:0] ds, input logic [3:0] rnds);
      words_t w, n;
      logic [31:0] t;
      w = w_in;
      for (int j = 0; j < int'(rnds); j++) begin
         t = (w[0] ^ w[NWORDS-1]) + ((w[1] << 5) | (w[1] >> 27)) + ((32'(ds) << 4) | 32'(j));
         for (int k = 0; k < NWORDS - 1; k++) n[k] = w[k+1];
         n[NWORDS-1] = t;
         n[0] = n[0] ^ t;
         w = n;
      end
      return w;
   endfunction

   typedef struct {
      int            n;
      logic [CW-1:0] c;
      logic [31:0]   r;
      logic [XW-1:0] x;
      logic [1:0]    dom;
      logic [3:0]    rnd;
      int            pct;
      logic [CW-1:0] exp_c;
      logic [31:0]   exp_r;
      logic [XW-1:0] exp_x;
   } vec_t;

   vec_t vecs [NVEC];
   logic [31:0] exp_q[$];

   // Expected block stream and final state: block 0 is r, each later block follows one F.
   task automatic model_run(inout vec_t v);
      words_t w;
      w = to_words(v.c, v.r, v.x);
      exp_q.delete();
      for (int b = 0; b < v.n; b++) begin
         if (b > 0) w = perm(w, {v.dom, 2'b10}, v.rnd);
         exp_q.push_back(w[0]);
      end
      v.exp_c = words_c(w);
      v.exp_r = w[0];
      v.exp_x = {w[2], w[1]};
   endtask

   function automatic logic [CW-1:0] rand_c();
      logic [CW-1:0] v;
      for (int k = 0; k < 10; k++) v[32*k +: 32] = $urandom;
      return v;
   endfunction

   function automatic vec_t mk(input int n, input logic [31:0] rr, input logic [1:0] dom,
                               input logic [3:0] rnd, input int pct);
      vec_t v;
      v.n = n; v.c = rand_c(); v.r = rr; v.x = {$urandom, $urandom};
      v.dom = dom; v.rnd = rnd; v.pct = pct;
      v.exp_c = '0; v.exp_r = '0; v.exp_x = '0;
      return v;
   endfunction

   task automatic pulse_reset();
      @(negedge clk); reset = 1'b1; start = 1'b0; out_ready = 1'b0;
      @(negedge clk); reset = 1'b0;
   endtask

   // Issue one request and follow it to done; optionally fire a foreign start mid-run.
   task automatic run_req(input vec_t vin, input int inject_cycle);
      vec_t v;
      int idx, budget;
      bit stalled, expect_done, finished;
      logic [31:0] stall_blk;
      logic stall_last;
      v = vin;
      model_run(v);
      @(negedge clk);
      start = 1'b1; c = v.c; r = v.r; x = v.x; nblocks = NW'(v.n);
      domain = v.dom; rounds = v.rnd; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      if (v.n == 0) begin
         chk("zero_done_latency", done, 1'b1);
         chk("zero_no_valid", out_valid, 1'b0);
         @(negedge clk);
         chk("zero_no_valid_after", out_valid, 1'b0);
      end else begin
         chk("first_valid_latency", out_valid, 1'b1);
         idx = 0; stalled = 0; expect_done = 0; finished = 0;
         budget = 100 + v.n * (int'(v.rnd) + 8) * 4;
         for (int cyc = 1; cyc <= budget; cyc++) begin
            if (cyc == inject_cycle) begin
               start = 1'b1; c = ~v.c; r = ~v.r; nblocks = NW'(v.n + 5); rounds = v.rnd + 4'd1;
            end else begin
               start = 1'b0;
            end
            if (expect_done) begin
               chk("done_after_last", done, 1'b1);
               chk("valid_low_at_done", out_valid, 1'b0);
               chk("busy_low_at_done", busy, 1'b0);
               finished = 1;
               break;
            end
            if (stalled) begin
               chk("stall_valid_held", out_valid, 1'b1);
               chk("stall_block_stable", out_block, stall_blk);
               chk("stall_last_stable", out_last, stall_last);
            end
            if (out_valid) begin
               chk("busy_while_valid", busy, 1'b1);
               out_ready = ($urandom_range(99) < v.pct);
               if (out_ready) begin
                  chk("beat_block", out_block, (idx < exp_q.size()) ? exp_q[idx] : 32'hx);
                  chk("beat_last", out_last, (idx == v.n - 1));
                  idx++;
                  stalled = 0;
                  if (idx == v.n) expect_done = 1;
               end else begin
                  stalled = 1; stall_blk = out_block; stall_last = out_last;
               end
            end else begin
               out_ready = 1'($urandom_range(1));
               stalled = 0;
            end
            @(negedge clk);
         end
         start = 1'b0;
         if (!finished) begin
            chk("request_timeout", 1'b0, 1'b1);
            pulse_reset();
            return;
         end
         chk("beat_count", idx, v.n);
      end
      chk("final_cout", cout, v.exp_c);
      chk("final_rout", rout, v.exp_r);
      chk("final_xout", xout, v.exp_x);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_out_block"}, out_block, '0);
      chk({tag, "_out_valid"}, out_valid, 1'b0);
      chk({tag, "_out_last"}, out_last, 1'b0);
      chk({tag, "_cout"}, cout, '0);
      chk({tag, "_rout"}, rout, '0);
      chk({tag, "_xout"}, xout, '0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
   endtask

   initial begin
      vec_t va, vb;
      bit seen;
      reset = 1'b1; start = 1'b0; out_ready = 1'b0;
      c = '0; r = '0; x = '0; nblocks = '0; domain = '0; rounds = '0;

      vecs[0] = mk(1,   32'hDEADBEEF, 2'd1, 4'd4,  100);
      vecs[1] = mk(0,   $urandom,     2'd2, 4'd3,  100);
      vecs[2] = mk(4,   $urandom,     2'd3, 4'd5,  50);
      vecs[3] = mk(4,   $urandom,     2'd2, 4'd0,  50);
      vecs[4] = mk(2,   $urandom,     2'd0, 4'd15, 30);
      vecs[5] = mk(7,   $urandom,     2'd1, 4'd2,  70);
      vecs[6] = mk(255, $urandom,     2'd3, 4'd1,  100);
      for (int k = 7; k < int'(NVEC); k++)
         vecs[k] = mk(int'($urandom_range(12, 1)), $urandom, 2'($urandom_range(3)),
                      4'($urandom_range(15)), int'($urandom_range(90, 20)));
      for (int k = 0; k < int'(NVEC); k++) model_run(vecs[k]);

      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b0;

      for (int k = 0; k < int'(NVEC); k++) run_req(vecs[k], -1);

      // Abort: stall beat index 1 of a 3-block request, then reset.
      va = mk(3, $urandom, 2'd1, 4'd3, 100);
      @(negedge clk);
      start = 1'b1; c = va.c; r = va.r; x = va.x; nblocks = 8'd3;
      domain = va.dom; rounds = va.rnd; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("abort_first_valid", out_valid, 1'b1);
      @(negedge clk);
      out_ready = 1'b0;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         if (out_valid) begin seen = 1; break; end
         @(negedge clk);
      end
      chk("abort_second_valid_seen", seen, 1'b1);
      repeat (10) @(negedge clk);
      chk("abort_stalled_valid", out_valid, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      chk_all_zero("abort");
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_idle_valid", out_valid, 1'b0);
      chk("abort_idle_busy", busy, 1'b0);
      chk("abort_idle_done", done, 1'b0);
      vb = mk(2, $urandom, 2'd2, 4'd2, 60);
      run_req(vb, -1);

      // Start while busy in PERM_WAIT must be ignored.
      va = mk(3, $urandom, 2'd0, 4'd6, 100);
      run_req(va, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/squeeze.md
Name: squeeze

Overview:
- Output phase of the sponge datapath. Takes the permuted state (c, r, x) left by absorb when its done is high.
- Streams a requested number of RWIDTH-bit output blocks over a valid/ready interface.
- Invokes the F permutation core between consecutive blocks.
- Returns the final state for later phases or for ratcheting.

Parameters:
CWIDTH, 320, capacity width
RWIDTH, 32, rate width = output block width
XWIDTH, 64, extra lane width (multiple of 32)
IWIDTH, 128, F data-input width; F data input is driven all-zero
NWIDTH, 8, width of block-count request

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
start  input  1  one-cycle request; sampled only in IDLE or DONE
c  input  CWIDTH  capacity state from absorb
r  input  RWIDTH  rate state from absorb
x  input  XWIDTH  extra state from absorb
nblocks  input  NWIDTH  number of output blocks requested (0..2^NWIDTH-1)
domain  input  2  domain-separation bits
rounds  input  4  round count passed to F
out_block  output  RWIDTH  output block data
out_valid  output  1  out_block valid
out_ready  input  1  consumer accepts block
out_last  output  1  high with the final block's out_valid
cout  output  CWIDTH  final capacity state
rout  output  RWIDTH  final rate state
xout  output  XWIDTH  final extra state
busy  output  1  high in every state except IDLE/DONE
done  output  1  squeeze complete; held until next accepted start

Behaviour:
- Reset: state=IDLE, F held in reset. All outputs 0 (out_block, out_valid, out_last, cout, rout, xout, busy, done). Internal regs and block counter cleared. Reset mid-operation aborts immediately; no further beats are emitted.
- All outputs are registered or decoded from registered state only. No combinational path from out_ready to out_valid.
- F instance: XWORDS32=XWIDTH/32, DS_WIDTH=4, ROUND_COUNT=4, RWIDTH=RWIDTH. F reset = reset | f_reset. F inputs: i=0, rounds=latched rounds, ds={domain_reg,1'b1,1'b0}, c/r/x from internal regs.
- Block 0 is r as given; absorb's final F already ran. Every later block is preceded by exactly one F call, so total F calls = nblocks-1 (0 if nblocks≤1).
- IDLE / DONE, start=1 at edge T:
  - latch c, r, x, nblocks, domain, rounds; cnt=0; done cleared.
  - next state EMIT, or DONE if nblocks=0.
- start while busy: ignored, no effect.
- EMIT:
  - out_valid=1, out_block=rReg, out_last=(cnt==nblocks-1).
  - out_block/out_last stable while out_valid && !out_ready.
  - handshake (out_valid&&out_ready) at edge: cnt+1. If last → DONE, else → PERM_START.
- PERM_START: f_reset=1 for exactly one cycle; out_valid=0 → PERM_WAIT.
- PERM_WAIT:
  - f_reset=0; wait for F done.
  - At the edge where F done=1: capture F cout/rout/xout into regs → EMIT.
  - Stalls indefinitely if F never completes. Only reset recovers.
- DONE:
  - done=1; cout/rout/xout = final regs, updated on entry.
  - For nblocks=0, outputs equal the inputs latched at start.
- Timing:
  - start at T → out_valid from T+1 (nblocks≥1) or done from T+1 (nblocks=0).
  - last handshake at edge E → done=1 in cycle after E.
  - F latency L → next out_valid rises 2+L cycles after previous handshake.
- Counter: NWIDTH bits. nblocks=2^NWIDTH-1 must complete without wrap. out_last asserted only on beat index nblocks-1.

Test Plan:
- nblocks=1, r=32'hDEADBEEF, out_ready=1 → single beat out_block=32'hDEADBEEF with out_last=1; zero F calls; done next cycle; cout=c, rout=r, xout=x.
- nblocks=0 → done high 1 cycle after start; out_valid never asserted; cout/rout/xout equal inputs.
- nblocks=4, out_ready random (~50%) → exactly 4 handshakes; out_block stable during stalls; out_last only on 4th; 3 F calls. Blocks and final state match golden sponge model with ds=4'b{domain}10.
- Beat 2 of nblocks=3 stalled 10 cycles, then reset pulsed → all outputs 0 next cycle, state IDLE. A new start with nblocks=2 then completes normally.
- start pulsed during PERM_WAIT with different c/nblocks → ignored; original request completes with original values.
- nblocks=255, out_ready=1 → 255 beats, out_last on beat 255 only, 254 F calls, done asserted, no counter wrap.
